// File: rtl/sm_pkg.sv
// Shared types and helpers for the sign-magnitude subtract-accumulator.
// Sign is the MSB of each word, and the remaining bits hold the magnitude.
package sm_pkg;

    localparam int SM_DW       = 8;
    localparam int SM_SIGN_BIT = SM_DW - 1;
    localparam int SM_MAG_MSB  = SM_DW - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A zero magnitude always reports a positive sign, so -0 never appears.
    function automatic logic sm_norm_sign(input logic sgn, input logic mag_nz);
        return sgn & mag_nz;
    endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder.
// carry flags a magnitude carry out of an equal-sign add.
module sm_add_core
    import sm_pkg::*;
#(
    parameter int DW = SM_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          carry
);

    logic          a_s;
    logic          b_s;
    logic [DW-2:0] a_m;
    logic [DW-2:0] b_m;
    logic [DW-1:0] mag_sum;
    logic [DW-2:0] mag;
    logic          sgn;

    assign a_s = a[DW-1];
    assign b_s = b[DW-1];
    assign a_m = a[DW-2:0];
    assign b_m = b[DW-2:0];
    assign mag_sum = {1'b0, a_m} + {1'b0, b_m};

    always_comb begin
        sgn   = a_s;
        mag   = mag_sum[DW-2:0];
        carry = 1'b0;
        if (a_s == b_s) begin
            carry = mag_sum[DW-1];
        end else if (a_m > b_m) begin
            mag = a_m - b_m;
        end else begin
            sgn = b_s;
            mag = b_m - a_m;
        end
        sum = {sm_norm_sign(sgn, |mag), mag};
    end

endmodule

// File: rtl/sm_sub_accumulator.sv
// Sequential sign-magnitude subtract-accumulator with a valid/ready result.
// Define SM_SUB_ACC_SAT_EN to saturate instead of wrapping on magnitude overflow.
module sm_sub_accumulator
    import sm_pkg::*;
#(
    parameter int DW  = SM_DW,
    parameter int LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] init,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          overflow
);

    localparam int CW = $clog2(LEN + 1);

    state_e        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [DW-1:0] neg_b;
    logic [DW-1:0] sum;
    logic [DW-1:0] res;
    logic [DW-1:0] init_n;
    logic          carry;
    logic          accept;
    logic          last;

    // Subtraction is an add of the operand with its sign flipped.
    assign neg_b  = {~in_data[DW-1], in_data[DW-2:0]};
    assign init_n = {sm_norm_sign(init[DW-1], |init[DW-2:0]), init[DW-2:0]};

    sm_add_core #(.DW(DW)) u_add (
        .a     (acc_q),
        .b     (neg_b),
        .sum   (sum),
        .carry (carry)
    );

`ifdef SM_SUB_ACC_SAT_EN
    // Carry only arises from equal signs, so the accumulator sign is the result sign.
    assign res = carry ? {acc_q[DW-1], {(DW-1){1'b1}}} : sum;
`else
    assign res = sum;
`endif

    assign accept = in_valid && (state_q == ACC);
    assign last   = (cnt_q == CW'(LEN - 1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = init_n;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = res;
                    cnt_d = cnt_q + CW'(1);
                    if (carry) ovf_d = 1'b1;
                    if (last) begin
                        out_d   = res;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACC) || (state_q == DONE);
    assign out_data  = out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_sm_sub_accumulator.sv
// Scoreboard bench for sm_sub_accumulator (DW=8, LEN=4).
// Expected results are queued at issue time and popped by a monitor.
module tb_sm_sub_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] init;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       overflow;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [8:0] sb[$];

    sm_sub_accumulator #(.DW(8), .LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .init      (init),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops one expected result per completed output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(out_data), 32'hDEAD);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e[7:0]));
                check("overflow", 32'(overflow), 32'(e[8]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] v);
        start = 1'b1;
        init  = v;
        tick();
        start = 1'b0;
        init  = 8'h55;
    endtask

    task automatic send(input logic [7:0] d);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            ok = in_ready;
            tick();
            n++;
        end
        if (!ok) check("send_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
        in_data  = 8'h7F;
    endtask

    task automatic run_op(input logic [7:0] iv, input logic [31:0] ops,
                          input logic [7:0] exp_d, input logic exp_o,
                          input bit gaps, input bit hold);
        sb.push_back({exp_o, exp_d});
        pulse_start(iv);
        if (hold) out_ready = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'h3C;
                tick();
                tick();
            end
            if (i == 0) check("valid_before_last", 32'(out_valid), 32'd0);
            send(ops[i*8 +: 8]);
        end
        check("latency_valid", 32'(out_valid), 32'd1);
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                if (k == 1) begin
                    start    = 1'b1;
                    init     = 8'h11;
                    in_valid = 1'b1;
                    in_data  = 8'h22;
                end
                check("in_ready_done", 32'(in_ready), 32'd0);
                tick();
                start    = 1'b0;
                in_valid = 1'b0;
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(exp_d));
                check("hold_ovf", 32'(overflow), 32'(exp_o));
            end
            out_ready = 1'b1;
        end
        tick();
        check("valid_drop", 32'(out_valid), 32'd0);
        check("data_held", 32'(out_data), 32'(exp_d));
    endtask

    initial begin
        logic [7:0] ovf_exp;
        int         n;
`ifdef SM_SUB_ACC_SAT_EN
        ovf_exp = 8'h7F;
`else
        ovf_exp = 8'h16;
`endif
        rst       = 1'b1;
        start     = 1'b0;
        init      = 8'h00;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Operand offered in IDLE must be ignored.
        in_valid = 1'b1;
        in_data  = 8'h09;
        tick();
        in_valid = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);

        run_op(8'h05, 32'h0301_8200, 8'h03, 1'b0, 1'b0, 1'b0);
        check("busy_acc_done", 32'(busy), 32'd0);
        run_op(8'h02, 32'h0700_0000, 8'h85, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 32'h0484_0000, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(8'h64, 32'hB200_0000, ovf_exp, 1'b1, 1'b0, 1'b0);
        // Overflow is cleared by the next start.
        run_op(8'h0A, 32'h0102_0304, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op(8'h10, 32'h0101_0101, 8'h0C, 1'b0, 1'b0, 1'b1);

        // Reset mid-operation discards the in-flight work.
        pulse_start(8'h20);
        check("busy_acc", 32'(busy), 32'd1);
        send(8'h01);
        send(8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_out_data", 32'(out_data), 32'd0);
        check("mrst_overflow", 32'(overflow), 32'd0);
        run_op(8'h01, 32'h0101_0101, 8'h83, 1'b0, 1'b0, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
